// File: rtl/vx_commit_arbiter.sv
// Purpose: round-robin arbiter sharing one writeback port among the commit streams, locking on multi-beat packets.
// Latency: one cycle; a beat accepted on req_* appears on wb_* after the next rising edge.
// Backpressure: req_ready drops to zero while the output stage holds a beat that wb_ready does not take.
module vx_commit_arbiter #(
  parameter int NUM_REQS      = 5,
  parameter int DATAW         = 64,
  parameter int PERF_CTR_BITS = 44,
  localparam int IDXW         = $clog2(NUM_REQS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       req_valid,
  input  logic [NUM_REQS*DATAW-1:0] req_data,
  input  logic [NUM_REQS-1:0]       req_eop,
  output logic [NUM_REQS-1:0]       req_ready,
  output logic                      wb_valid,
  output logic [DATAW-1:0]          wb_data,
  output logic                      wb_eop,
  output logic [IDXW-1:0]           wb_idx,
  input  logic                      wb_ready,
  output logic [PERF_CTR_BITS-1:0]  perf_conflict_stalls
);

  logic [IDXW-1:0]     rr_ptr;
  logic                locked;
  logic [IDXW-1:0]     lock_idx;
  logic                stage_free;
  logic [NUM_REQS-1:0] grant;
  logic [IDXW-1:0]     grant_idx;
  logic [IDXW-1:0]     cand;
  logic                found;
  logic                any_xfer;
  logic                win_eop;
  logic [DATAW-1:0]    win_data;

  // The stage can take a new beat when empty or when its current beat drains this cycle.
  assign stage_free = !wb_valid || wb_ready;

  // Pick the winner: the lock holder only while locked, otherwise first valid after rr_ptr.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    if (reset && stage_free) begin
      if (locked) begin
        if (req_valid[lock_idx]) begin
          grant[lock_idx] = 1'b1;
          grant_idx       = lock_idx;
        end
      end else begin
        for (int k = 1; k <= NUM_REQS; k++) begin
          cand = IDXW'((int'(rr_ptr) + k) % NUM_REQS);
          if (!found && req_valid[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = cand;
          end
        end
      end
    end
  end

  assign req_ready = grant;
  assign any_xfer  = |grant;
  assign win_eop   = req_eop[grant_idx];
  assign win_data  = req_data[grant_idx*DATAW +: DATAW];

  // One-entry output stage: load on a transfer, empty on drain, otherwise hold.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_eop   <= 1'b0;
      wb_idx   <= '0;
    end else if (any_xfer) begin
      wb_valid <= 1'b1;
      wb_data  <= win_data;
      wb_eop   <= win_eop;
      wb_idx   <= grant_idx;
    end else if (wb_ready) begin
      wb_valid <= 1'b0;
    end
  end

  // Round-robin pointer and packet lock; a non-eop beat locks, an eop beat releases.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr   <= IDXW'(NUM_REQS - 1);
      locked   <= 1'b0;
      lock_idx <= '0;
    end else if (any_xfer) begin
      rr_ptr <= grant_idx;
      if (win_eop) begin
        locked <= 1'b0;
      end else begin
        locked   <= 1'b1;
        lock_idx <= grant_idx;
      end
    end
  end

  // Count cycles where some valid requester was left waiting; wraps on overflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_conflict_stalls <= '0;
    end else if (|(req_valid & ~grant)) begin
      perf_conflict_stalls <= perf_conflict_stalls + PERF_CTR_BITS'(1);
    end
  end

endmodule

// File: tb/tb_vx_commit_arbiter.sv
// Purpose: randomized and directed checking of vx_commit_arbiter against a queue-free behavioural model.
// Latency: model predicts grants combinationally and wb_* one edge later.
// Backpressure: wb_ready is randomized; model predicts zero grants while the stage is blocked.
module tb_vx_commit_arbiter;
  localparam int NUM   = 5;
  localparam int DATAW = 64;
  localparam int PCB   = 44;
  localparam int IDXW  = $clog2(NUM);

  logic                   clk;
  logic                   reset;
  logic [NUM-1:0]         req_valid;
  logic [NUM*DATAW-1:0]   req_data;
  logic [NUM-1:0]         req_eop;
  logic [NUM-1:0]         req_ready;
  logic                   wb_valid;
  logic [DATAW-1:0]       wb_data;
  logic                   wb_eop;
  logic [IDXW-1:0]        wb_idx;
  logic                   wb_ready;
  logic [PCB-1:0]         perf_conflict_stalls;

  int checks = 0;
  int errors = 0;

  vx_commit_arbiter #(.NUM_REQS(NUM), .DATAW(DATAW), .PERF_CTR_BITS(PCB)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_eop(req_eop), .req_ready(req_ready),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_eop(wb_eop), .wb_idx(wb_idx),
    .wb_ready(wb_ready), .perf_conflict_stalls(perf_conflict_stalls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state
  bit             live = 0;
  bit             m_valid;
  logic [DATAW-1:0] m_data;
  bit             m_eop;
  int             m_idx;
  int             m_rr;
  bit             m_locked;
  int             m_lock_idx;
  logic [PCB-1:0] m_cnt;

  // Winner = valid requester with the smallest circular distance past the last winner.
  function automatic int exp_grant();
    int best = -1;
    int bd = NUM;
    if (!reset) return -1;
    if (m_valid && !wb_ready) return -1;
    if (m_locked) return req_valid[m_lock_idx] ? m_lock_idx : -1;
    for (int i = 0; i < NUM; i++) begin
      if (req_valid[i]) begin
        int d;
        d = (i - m_rr - 1 + 2 * NUM) % NUM;
        if (d < bd) begin
          bd = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [NUM-1:0] mask_of(input int g);
    logic [NUM-1:0] m = '0;
    if (g >= 0) m[g] = 1'b1;
    return m;
  endfunction

  always @(posedge clk) begin
    int g;
    if (!reset) begin
      m_valid = 0; m_data = '0; m_eop = 0; m_idx = 0;
      m_rr = NUM - 1; m_locked = 0; m_lock_idx = 0; m_cnt = '0;
      live = 1;
    end else if (live) begin
      g = exp_grant();
      if ((req_valid & ~mask_of(g)) != '0) m_cnt = m_cnt + 1'b1;
      if (g >= 0) begin
        m_valid = 1;
        m_data  = req_data[g*DATAW +: DATAW];
        m_eop   = req_eop[g];
        m_idx   = g;
        m_rr    = g;
        if (req_eop[g]) m_locked = 0;
        else begin
          m_locked = 1;
          m_lock_idx = g;
        end
      end else if (wb_ready) begin
        m_valid = 0;
      end
    end
  end

  // Compare every cycle once the model has seen a reset edge.
  always @(negedge clk) begin
    int g;
    if (live) begin
      g = exp_grant();
      check("req_ready", 64'(req_ready), 64'(mask_of(g)));
      check("wb_valid", 64'(wb_valid), 64'(m_valid));
      check("wb_data", wb_data, m_data);
      check("wb_eop", 64'(wb_eop), 64'(m_eop));
      check("wb_idx", 64'(wb_idx), 64'(m_idx));
      check("perf", 64'(perf_conflict_stalls), 64'(m_cnt));
      check("onehot0", 64'($onehot0(req_ready)), 64'd1);
      check("grant_invalid", 64'(req_ready & ~req_valid), 64'd0);
      if (m_locked)
        check("grant_not_lock", 64'(req_ready & ~mask_of(m_lock_idx)), 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic set_data(input int i, input logic [DATAW-1:0] v);
    req_data[i*DATAW +: DATAW] = v;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_valid = '0;
    req_eop = '1;
    wb_ready = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    req_valid = '0;
    req_data = '0;
    req_eop = '1;
    wb_ready = 1'b1;
    repeat (2) tick();
    settle();
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_wb_data", wb_data, 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    tick();
    reset = 1'b1;

    // Single requester
    req_valid = 5'b00010; set_data(1, 64'hA5); req_eop = '1;
    settle();
    check("single_ready", 64'(req_ready), 64'h02);
    check("single_perf0", 64'(perf_conflict_stalls), 64'd0);
    tick();
    req_valid = '0;
    settle();
    check("single_wb_valid", 64'(wb_valid), 64'd1);
    check("single_wb_data", wb_data, 64'hA5);
    check("single_wb_idx", 64'(wb_idx), 64'd1);
    check("single_perf", 64'(perf_conflict_stalls), 64'd0);
    tick();

    // All five valid: rotation 0..4,0
    do_reset();
    for (int i = 0; i < NUM; i++) set_data(i, 64'h100 + 64'(i));
    req_valid = '1; req_eop = '1;
    for (int c = 0; c < 6; c++) begin
      settle();
      check("rr_ready", 64'(req_ready), 64'(mask_of(c % NUM)));
      check("rr_perf", 64'(perf_conflict_stalls), 64'(c));
      tick();
    end
    req_valid = '0;
    settle();
    check("rr_perf6", 64'(perf_conflict_stalls), 64'd6);
    check("rr_last_idx", 64'(wb_idx), 64'd0);
    tick();

    // Lock: req1 three beats while req0/req2 wait
    do_reset();
    req_valid = 5'b00010; req_eop = 5'b11101;
    settle(); check("lock_r1", 64'(req_ready), 64'h02); tick();
    req_valid = 5'b00111;
    settle(); check("lock_r2", 64'(req_ready), 64'h02); check("lock_idx1", 64'(wb_idx), 64'd1); tick();
    req_eop = '1;
    settle(); check("lock_r3", 64'(req_ready), 64'h02); check("lock_idx2", 64'(wb_idx), 64'd1); tick();
    req_valid = 5'b00101;
    settle(); check("lock_r4", 64'(req_ready), 64'h04); check("lock_idx3", 64'(wb_idx), 64'd1); tick();
    settle(); check("lock_r5", 64'(req_ready), 64'h01); check("lock_idx4", 64'(wb_idx), 64'd2); tick();
    req_valid = '0;
    settle(); check("lock_idx5", 64'(wb_idx), 64'd0); tick();

    // Backpressure hold then no-bubble reload
    do_reset();
    req_valid = 5'b00100; set_data(2, 64'h1234); req_eop = '1;
    tick();
    req_valid = 5'b01000; set_data(3, 64'h5555); set_data(2, 64'h9999); wb_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      settle();
      check("bp_hold_data", wb_data, 64'h1234);
      check("bp_hold_valid", 64'(wb_valid), 64'd1);
      check("bp_ready0", 64'(req_ready), 64'd0);
      tick();
    end
    wb_ready = 1'b1;
    settle(); check("bp_release_ready", 64'(req_ready), 64'h08); tick();
    req_valid = '0;
    settle();
    check("bp_new_data", wb_data, 64'h5555);
    check("bp_new_valid", 64'(wb_valid), 64'd1);
    check("bp_perf", 64'(perf_conflict_stalls), 64'd4);
    tick();

    // Reset mid-lock
    do_reset();
    req_valid = 5'b01000; req_eop = 5'b10111;
    tick();
    reset = 1'b0;
    settle(); check("rst_lock_ready0", 64'(req_ready), 64'd0);
    tick();
    reset = 1'b1; req_valid = 5'b01001; req_eop = '1;
    settle();
    check("rst_lock_wbv", 64'(wb_valid), 64'd0);
    check("rst_lock_ready", 64'(req_ready), 64'h01);
    tick();
    req_valid = '0;
    settle(); check("rst_lock_idx", 64'(wb_idx), 64'd0); tick();

    // Lock holder idle
    do_reset();
    req_valid = 5'b10000; req_eop = 5'b01111;
    tick();
    req_valid = 5'b00001; req_eop = '1;
    for (int c = 0; c < 3; c++) begin
      settle(); check("idle_ready0", 64'(req_ready), 64'd0); tick();
    end
    settle();
    check("idle_perf", 64'(perf_conflict_stalls), 64'd3);
    check("idle_wbv", 64'(wb_valid), 64'd0);
    req_valid = '0;
    tick();

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      req_valid = NUM'($urandom);
      for (int i = 0; i < NUM; i++) begin
        set_data(i, {$urandom, $urandom});
        req_eop[i] = ($urandom_range(0, 9) < 7);
      end
      wb_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 99) != 0);
      tick();
    end
    reset = 1'b1;
    req_valid = '0;
    wb_ready = 1'b1;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vx_commit_arbiter.md
Name: vx_commit_arbiter

Overview:
- Shares the single GPR/scoreboard writeback port among the execution units: ALU, LSU, CSR, FPU and GPU commit streams.
- Performs round-robin arbitration with packet locking on eop, so that multi-beat writebacks stay contiguous.
- Registers the winner into a one-entry output stage that drives the issue stage's writeback interface.
- Exports a conflict-stall counter for the perf pipeline.

Parameters:
- NUM_REQS, 5, number of commit requesters (index 0 = ALU, 1 = LSU, 2 = CSR, 3 = FPU, 4 = GPU).
- DATAW, 64, width of one writeback payload (uuid/wid/PC/tmask/rd/data packed by the caller; opaque to this block).
- PERF_CTR_BITS, 44, width of the stall counter.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-low reset: state clears on the rising edge of clk while reset==0.
- req_valid  input  NUM_REQS  per-requester valid.
- req_data  input  NUM_REQS*DATAW  per-requester payload; requester i occupies bits [i*DATAW +: DATAW].
- req_eop  input  NUM_REQS  per-requester end-of-packet flag.
- req_ready  output  NUM_REQS  per-requester accept; one-hot or zero.
- wb_valid  output  1  registered writeback valid.
- wb_data  output  DATAW  registered payload.
- wb_eop  output  1  registered eop.
- wb_idx  output  $clog2(NUM_REQS)  index of the requester whose beat is in the output stage.
- wb_ready  input  1  writeback sink accept.
- perf_conflict_stalls  output  PERF_CTR_BITS  cycles with at least one stalled requester.

Behaviour:
- Transfers:
  - A transfer on requester i occurs when req_valid[i] && req_ready[i].
  - An output transfer occurs when wb_valid && wb_ready.
- Output stage:
  - One entry. stage_free = !wb_valid || wb_ready (same-cycle pass-through).
  - req_ready is all-zero whenever stage_free==0.
  - req_ready is combinational from req_valid, the lock state, the rr pointer and wb_ready. It must never depend on wb_data.
- Latency:
  - An accepted beat appears on wb_* the next cycle.
  - Sustained throughput is 1 beat/cycle when wb_ready is held at 1.
- Round-robin:
  - rr_ptr holds the last granted index. Search order is rr_ptr+1, rr_ptr+2, … modulo NUM_REQS.
  - The first valid requester in that order wins.
  - rr_ptr updates to the winner only on a transfer.
  - Wrap: after index NUM_REQS-1, the search starts at 0.
- Lock:
  - A transfer with req_eop[i]==0 sets locked=1 and lock_idx=i.
  - While locked, only lock_idx may be granted. Other valid requesters wait even if lock_idx is idle.
  - A transfer from lock_idx with eop==1 clears locked in the same edge; normal round-robin resumes next cycle.
  - A single-beat packet (eop==1 on the first beat) never sets the lock.
- Output register:
  - On a transfer, wb_valid<=1, and wb_data/wb_eop/wb_idx load the winner's payload.
  - Else, if wb_ready, wb_valid<=0.
  - Else all wb_* hold.
  - While wb_valid && !wb_ready, wb_data/wb_eop/wb_idx must remain bit-stable.
- Stall counter:
  - Increments by 1 in any cycle where (req_valid & ~req_ready) != 0.
  - Saturation is not required; the counter wraps modulo 2^PERF_CTR_BITS.
- Reset values:
  - wb_valid=0, wb_data=0, wb_eop=0, wb_idx=0.
  - rr_ptr=NUM_REQS-1, so index 0 has first priority.
  - locked=0, lock_idx=0, perf_conflict_stalls=0.
  - req_ready=0 during reset.
- Reset mid-operation:
  - Reset asserted while locked or while wb_valid=1 discards the held beat and the lock. No beat is emitted during or after reset unless it is re-presented.
- Simultaneous events:
  - A new winner loads and the old beat drains in the same cycle (wb_ready=1, stage full): there is no bubble.
  - The lock clears and a new grant does not occur in the same cycle for a different index: the lock release takes effect the following cycle.
- Invariants (asserted in sim):
  - req_ready is one-hot or zero.
  - No grant goes to an index with req_valid==0.
  - No grant goes to an index other than lock_idx while locked.

Test Plan:
- Single requester: only req 1 valid, wb_ready=1, payload 0xA5 eop=1 → req_ready=5'b00010 that cycle; next cycle wb_valid=1, wb_data=0xA5, wb_idx=1; counter stays 0.
- All five valid and single-beat every cycle from reset, wb_ready=1 → grants in order 0,1,2,3,4,0; counter increments by 1 each cycle (6 after 6 cycles).
- Lock: req 1 sends 3 beats (eop=0,0,1) while req 0 and req 2 stay valid → wb_idx sequence 1,1,1, then 2, then 0. The rr pointer sits at 1 after the lock, so 2 precedes 0.
- Backpressure: wb_ready=0 for 4 cycles with a beat held (data 0x1234) → wb_data holds 0x1234 and req_ready=0 for all 4 cycles; on wb_ready=1 the next winner loads with no bubble.
- Reset mid-lock: req 3 accepts beat eop=0, then reset=0 for 1 cycle → wb_valid=0, locked cleared; after release, req 0 and req 3 both valid grant 0 first.
- Lock holder idle: locked on req 4 with req_valid[4]=0 and req 0 valid for 3 cycles → no grant; counter +3; wb_valid=0 after the drain.
